basic_io_gen: RTL and testbench

BASIC_IO_GEN -- requirements
Module: basic_io_gen

---
 rtl/basic_io_gen.sv | 166 ++++++++++++++++
 tb/tb_basic_io_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/basic_io_gen.sv
// basic_io_gen: memory-mapped board I/O block.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   addr, data_in, we : CPU local bus (we = 0 writes on the rising edge)
//   data_out          : combinational readback of the register at addr
//   sw, btn           : raw switches and buttons (synchronised, buttons debounced)
//   led               : LED drive, active-high
//   seg, dp, an       : multiplexed 7-segment display, all active-low, registered
module basic_io_gen #(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SCAN_DIV        = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            addr,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  input  logic                  we,
  input  logic [15:0]           sw,
  input  logic [4:0]            btn,
  output logic [15:0]           led,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam logic [7:0]            MaskValid = 8'((1 << NUM_DIGITS) - 1);
  localparam logic [NUM_DIGITS-1:0] AnReset   = ~(NUM_DIGITS'(1) << (NUM_DIGITS - 1));

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;  4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;  4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;  4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;  4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;  default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  logic        wr_en;
  logic        dig_hit;
  logic [15:0] sw_s1_q, sw_s2_q;
  logic [4:0]  btn_s1_q, btn_s2_q;
  logic [4:0]  lvl_q, lvl_d;
  logic [15:0] db_cnt_q [5];
  logic [15:0] db_cnt_d [5];
  logic [4:0]  flags_q, flags_d, flag_clr;
  logic [15:0] led_q;
  logic [7:0]  dig_q [8];
  logic [1:0]  ctrl_q;   // bit0 hex_mode, bit1 blank
  logic [7:0]  mask_q;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  assign wr_en   = ~we;
  assign dig_hit = (addr[7:3] == 5'b00100) && (32'(addr[2:0]) < NUM_DIGITS);

  // Debounce: a differing sample extends the run, an equal sample restarts it.
  always_comb begin
    for (int b = 0; b < 5; b++) begin
      lvl_d[b]    = lvl_q[b];
      db_cnt_d[b] = '0;
      if (btn_s2_q[b] != lvl_q[b]) begin
        if (db_cnt_q[b] == 16'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d[b] = btn_s2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 16'd1;
        end
      end
    end
  end

  // Set has priority over a coincident write-1-to-clear.
  always_comb begin
    flag_clr = (wr_en && addr == 8'h03) ? data_in[4:0] : 5'b0;
    flags_d  = (flags_q & ~flag_clr) | (lvl_d & ~lvl_q);
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    idx_d      = idx_q;
    if (scan_cnt_q == 16'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_comb begin
    seg_d = ctrl_q[0] ? hex_glyph(dig_q[idx_q][3:0]) : dig_q[idx_q][6:0];
    dp_d  = ~(mask_q[idx_q] & ~ctrl_q[1]);
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      // Digit 0 is leftmost, so it drives the top enable bit.
      an_d[i] = ctrl_q[1] || (i != int'(NUM_DIGITS) - 1 - int'(idx_q));
    end
  end

  always_comb begin
    data_out = '0;
    case (addr)
      8'h00:   data_out = sw_s2_q[7:0];
      8'h01:   data_out = sw_s2_q[15:8];
      8'h02:   data_out = {3'b000, lvl_q};
      8'h03:   data_out = {3'b000, flags_q};
      8'h10:   data_out = led_q[7:0];
      8'h11:   data_out = led_q[15:8];
      8'h30:   data_out = {6'b0, ctrl_q};
      8'h31:   data_out = mask_q;
      default: if (dig_hit) data_out = dig_q[addr[2:0]];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      lvl_q      <= '0;
      for (int b = 0; b < 5; b++) db_cnt_q[b] <= '0;
      flags_q    <= '0;
      led_q      <= '0;
      for (int i = 0; i < 8; i++) dig_q[i] <= 8'h3F;
      ctrl_q     <= '0;
      mask_q     <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= 7'h3F;
      dp_q       <= 1'b1;
      an_q       <= AnReset;
    end else begin
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
      lvl_q      <= lvl_d;
      for (int b = 0; b < 5; b++) db_cnt_q[b] <= db_cnt_d[b];
      flags_q    <= flags_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      if (wr_en) begin
        if (addr == 8'h10) led_q[7:0]  <= data_in;
        if (addr == 8'h11) led_q[15:8] <= data_in;
        if (addr == 8'h30) ctrl_q      <= data_in[1:0];
        if (addr == 8'h31) mask_q      <= data_in & MaskValid;
        if (dig_hit)       dig_q[addr[2:0]] <= data_in;
      end
    end
  end

  assign led = led_q;
  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_basic_io_gen.sv
module tb_basic_io_gen;

  localparam int ND = 4;
  localparam int DB = 16;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    addr, data_in, data_out;
  logic          we;
  logic [15:0]   sw;
  logic [4:0]    btn;
  logic [15:0]   led;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;

  basic_io_gen #(
    .NUM_DIGITS     (ND),
    .DEBOUNCE_CYCLES(DB),
    .SCAN_DIV       (SD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .we      (we),
    .sw      (sw),
    .btn     (btn),
    .led     (led),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; the scan position follows from this alone.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the register file.
  logic [15:0] led_m, sw_m;
  logic [7:0]  dig_m [ND];
  logic [1:0]  ctrl_m;
  logic [7:0]  mask_m;
  logic [4:0]  flags_m, lvl_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    led_m = '0; ctrl_m = '0; mask_m = '0; flags_m = '0; lvl_m = '0;
    for (int i = 0; i < ND; i++) dig_m[i] = 8'h3F;
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00: return sw_m[7:0];
      8'h01: return sw_m[15:8];
      8'h02: return {3'b0, lvl_m};
      8'h03: return {3'b0, flags_m};
      8'h10: return led_m[7:0];
      8'h11: return led_m[15:8];
      8'h30: return {6'b0, ctrl_m};
      8'h31: return mask_m;
      default: begin
        if (a >= 8'h20 && int'(a) < 32 + ND) return dig_m[int'(a) - 32];
        return 8'h00;
      end
    endcase
  endfunction

  function automatic int exp_idx();
    return (cyc == 0) ? 0 : ((cyc - 1) / SD) % ND;
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; we = 1'b0;
    @(negedge clk);
    we = 1'b1;
    case (a)
      8'h03: flags_m &= ~d[4:0];
      8'h10: led_m[7:0] = d;
      8'h11: led_m[15:8] = d;
      8'h30: ctrl_m = d[1:0];
      8'h31: mask_m = d & 8'h0F;
      default: if (a >= 8'h20 && int'(a) < 32 + ND) dig_m[int'(a) - 32] = d;
    endcase
  endtask

  task automatic bus_read(input string tag, input logic [7:0] a);
    @(negedge clk);
    addr = a;
    #1 check_eq(tag, data_out, model_read(a));
  endtask

  // Call at a negedge at least one full cycle after the last write.
  task automatic check_display(input string tag);
    int i;
    logic [ND-1:0] an_e;
    i = exp_idx();
    an_e = ctrl_m[1] ? '1 : ~(ND'(1) << (ND - 1 - i));
    check_eq({tag, "_an"}, an, an_e);
    check_eq({tag, "_seg"}, seg, ctrl_m[0] ? glyph(dig_m[i][3:0]) : dig_m[i][6:0]);
    check_eq({tag, "_dp"}, dp, (mask_m[i] && !ctrl_m[1]) ? 1'b0 : 1'b1);
  endtask

  logic [7:0] addrs [16];

  initial begin
    int len, b, waited;
    logic [7:0] a;
    addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h20, 8'h21,
              8'h22, 8'h23, 8'h24, 8'h27, 8'h30, 8'h31, 8'h12, 8'h40};
    rst_n = 1'b0; we = 1'b1; addr = '0; data_in = '0; sw = '0; btn = '0;
    sw_m = '0;
    reset_model();

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_led", led, 16'h0);
    check_eq("rst_an", an, 4'b0111);
    check_eq("rst_dp", dp, 1'b1);
    addr = 8'h20;
    #1 check_eq("rst_dig0", data_out, 8'h3F);
    addr = 8'h03;
    #1 check_eq("rst_flags", data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Scan stepping from reset.
    for (int k = 0; k < 20; k++) begin
      #1 check_display("scan");
      @(negedge clk);
    end

    // LED write and readback.
    bus_write(8'h10, 8'hA5);
    bus_write(8'h11, 8'h3C);
    #1 check_eq("led", led, 16'h3CA5);
    bus_read("rd_led_lo", 8'h10);
    bus_read("rd_led_hi", 8'h11);

    // Switch synchroniser latency.
    @(negedge clk);
    sw = 16'hBEEF; addr = 8'h00;
    #1 check_eq("sw_lat0", data_out, 8'h00);
    @(negedge clk);
    #1 check_eq("sw_lat1", data_out, 8'h00);
    @(negedge clk);
    #1 check_eq("sw_lat2", data_out, 8'hEF);
    sw_m = 16'hBEEF;
    bus_read("sw_hi", 8'h01);

    // Short pulse rejected, long pulse accepted on the exact cycle.
    @(negedge clk);
    btn[2] = 1'b1;
    repeat (15) @(negedge clk);
    btn[2] = 1'b0;
    repeat (5) @(negedge clk);
    bus_read("short_lvl", 8'h02);
    bus_read("short_flag", 8'h03);
    @(negedge clk);
    btn[2] = 1'b1; addr = 8'h02;
    repeat (17) @(negedge clk);
    #1 check_eq("db_early", data_out, 8'h00);
    @(negedge clk);
    #1 check_eq("db_accept", data_out, 8'h04);
    lvl_m[2] = 1'b1; flags_m[2] = 1'b1;
    bus_read("press_flag", 8'h03);

    // Clear of bit2 and bit0 in the same cycle bit0 sets: set wins.
    @(negedge clk);
    btn[0] = 1'b1;
    repeat (17) @(negedge clk);
    addr = 8'h03; data_in = 8'h05; we = 1'b0;
    @(negedge clk);
    we = 1'b1;
    lvl_m[0] = 1'b1; flags_m = 5'b00001;
    bus_read("set_wins", 8'h03);
    bus_read("lvl_both", 8'h02);
    btn = '0;
    repeat (DB + 4) @(negedge clk);
    lvl_m = '0;
    bus_read("lvl_release", 8'h02);

    // Pulse lengths around the debounce threshold, then random ones.
    for (int t = 0; t < 8; t++) begin
      bus_write(8'h03, 8'h1F);
      b = $urandom_range(0, 4);
      len = (t == 0) ? DB - 1 : (t == 1) ? DB : $urandom_range(DB - 6, DB + 6);
      @(negedge clk);
      btn[b] = 1'b1;
      repeat (len) @(negedge clk);
      btn[b] = 1'b0;
      repeat (DB + 4) @(negedge clk);
      flags_m = (len >= DB) ? 5'(1 << b) : 5'b0;
      bus_read("pulse_flag", 8'h03);
      bus_read("pulse_lvl", 8'h02);
    end

    // Hex digit with decimal point, then blanking.
    bus_write(8'h30, 8'h01);
    bus_write(8'h21, 8'h0B);
    bus_write(8'h31, 8'h02);
    waited = 0;
    @(negedge clk);
    while (exp_idx() != 1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) check_eq("idx1_timeout", 32'(waited), 32'(0));
    #1 check_eq("hex_b_seg", seg, 7'b0000011);
    check_eq("hex_b_dp", dp, 1'b0);
    check_display("hex_b");
    bus_write(8'h30, 8'h03);
    @(negedge clk);
    #1 check_eq("blank_an", an, 4'b1111);
    check_eq("blank_dp", dp, 1'b1);

    // Random bus traffic against the model.
    for (int it = 0; it < 80; it++) begin
      a = addrs[$urandom_range(0, 15)];
      if ($urandom_range(0, 1) == 0) bus_write(a, 8'($urandom));
      else                           bus_read("rand_rd", a);
      if (it % 10 == 9) begin
        @(negedge clk);
        #1 check_display("rand_disp");
      end
    end

    // Asynchronous reset mid-scan.
    bus_write(8'h10, 8'h34);
    bus_write(8'h11, 8'h12);
    btn[1] = 1'b1;
    repeat (DB + 3) @(negedge clk);
    #2 rst_n = 1'b0;
    addr = 8'h03;
    #1;
    check_eq("arst_led", led, 16'h0);
    check_eq("arst_flags", data_out, 8'h00);
    check_eq("arst_an", an, 4'b0111);
    check_eq("arst_dp", dp, 1'b1);
    btn = '0;
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1 check_display("rescan");
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
